// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter: round-robin sharing of the single image_rom read port among NREQ sprite requesters.
// Define ROM_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin ring.

module image_rom_arbiter_lane (
    input  logic req,
    input  logic gnt,
    output logic elig
);
    // A lane granted last cycle sits out one slot, so nobody gets back-to-back accesses.
    assign elig = req & ~gnt;
endmodule

module image_rom_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                   pixel_clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic                   rom_en,
    input  logic [DATA_W-1:0]      rom_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic [NREQ-1:0]        rd_valid
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]              elig;
    logic [NREQ-1:0][ADDR_W-1:0]  lane_addr;
    logic [PTR_W-1:0]             ptr;
    logic [PTR_W-1:0]             win_idx;
    logic [PTR_W-1:0]             cand;
    logic                         win_any;
    logic [NREQ-1:0]              win_vec;
    logic [ROM_LAT:0][NREQ-1:0]   tag_pipe;
    int                           idx;

    assign lane_addr = req_addr;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        image_rom_arbiter_lane u_lane (
            .req  (req[i]),
            .gnt  (gnt[i]),
            .elig (elig[i])
        );
    end

    // Search upward from the slot after the last winner, wrapping modulo NREQ.
    always_comb begin
        win_any = 1'b0;
        win_idx = ptr;
        cand    = '0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(ptr) + k) % NREQ;
            cand = PTR_W'(idx);
`ifdef ROM_ARB_PRIO0_EN
            if (!win_any && elig[cand] && (idx != 0)) begin
`else
            if (!win_any && elig[cand]) begin
`endif
                win_any = 1'b1;
                win_idx = cand;
            end
        end
`ifdef ROM_ARB_PRIO0_EN
        if (elig[0]) begin
            win_any = 1'b1;
            win_idx = '0;
        end
`endif
        win_vec = '0;
        if (win_any)
            win_vec[win_idx] = 1'b1;
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt      <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            ptr      <= PTR_W'(NREQ - 1);
            tag_pipe <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            gnt    <= win_vec;
            rom_en <= win_any;
            if (win_any) begin
                rom_addr <= lane_addr[win_idx];
`ifdef ROM_ARB_PRIO0_EN
                if (win_idx != '0)
                    ptr <= win_idx;
`else
                ptr <= win_idx;
`endif
            end
            // Tag rides alongside the ROM access so the word returns to its issuer in grant order.
            tag_pipe[0] <= win_vec;
            for (int s = 1; s <= ROM_LAT; s++)
                tag_pipe[s] <= tag_pipe[s-1];
            rd_valid <= tag_pipe[ROM_LAT];
            if (|tag_pipe[ROM_LAT])
                rd_data <= rom_data;
        end
    end
endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed bench for image_rom_arbiter with a two-cycle ROM model (default parameters).
module tb_image_rom_arbiter;
    localparam int NREQ = 4, ADDR_W = 12, DATA_W = 8, ROM_LAT = 2;

    logic                   pixel_clk = 1'b0;
    logic                   reset_n   = 1'b0;
    logic [NREQ-1:0]        req       = '0;
    logic [NREQ*ADDR_W-1:0] req_addr  = '0;
    logic [NREQ-1:0]        gnt, rd_valid;
    logic [ADDR_W-1:0]      rom_addr;
    logic                   rom_en;
    logic [DATA_W-1:0]      rom_data, rd_data;
    logic [ADDR_W-1:0]      rom_a_q;
    int n_cmp = 0, n_err = 0;

    image_rom_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) dut (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_en    (rom_en),
        .rom_data  (rom_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [7:0] rom_f(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
    endfunction

    function automatic logic [11:0] addr_of(input int i);
        return 12'h400 + 12'(i * 'h35);
    endfunction

    // ROM with two cycles of read latency
    always @(posedge pixel_clk) begin
        rom_a_q  <= rom_addr;
        rom_data <= rom_f(rom_a_q);
    end

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

`ifdef ROM_ARB_PRIO0_EN
    int seq[8] = '{0, 1, 0, 2, 0, 3, 0, 1};
    int p6[6]  = '{0, 1, 0, 2, 0, 1};
`else
    int seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

    initial begin
        // Reset state and a single access
        tick();
        tick();
        check("rst_gnt", gnt, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        reset_n = 1'b1;
        req = 4'b0001;
        req_addr[0 +: ADDR_W] = 12'h123;
        tick();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_rom_addr", rom_addr, 12'h123);
        check("t1_rom_en", rom_en, 1);
        req = '0;
        tick();
        check("t1_gnt_off", gnt, 0);
        check("t1_rom_en_off", rom_en, 0);
        check("t1_rom_addr_hold", rom_addr, 12'h123);
        tick();
        check("t1_rdv_early", rd_valid, 0);
        tick();
        check("t1_rdv", rd_valid, 4'b0001);
        check("t1_rd_data", rd_data, 8'h97);
        tick();
        check("t1_rdv_off", rd_valid, 0);
        check("t1_rd_data_hold", rd_data, 8'h97);

        // All four requesters continuously
        do_reset();
        for (int i = 0; i < NREQ; i++)
            req_addr[i*ADDR_W +: ADDR_W] = addr_of(i);
        req = 4'b1111;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 8) begin
                check("t2_gnt", gnt, 1 << seq[k-1]);
                check("t2_rom_addr", rom_addr, addr_of(seq[k-1]));
            end else begin
                check("t2_gnt_idle", gnt, 0);
            end
            if (k >= 4 && k <= 11) begin
                check("t2_rdv", rd_valid, 1 << seq[k-4]);
                check("t2_rd_data", rd_data, rom_f(addr_of(seq[k-4])));
            end else begin
                check("t2_rdv_idle", rd_valid, 0);
            end
            if (k == 8)
                req = '0;
        end

        // Single continuous requester gets alternate cycles
        req = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t3_gnt", gnt, (k % 2 == 1) ? 4'b0100 : 4'b0000);
            check("t3_rom_en", rom_en, (k % 2 == 1) ? 1 : 0);
            if (k == 6)
                req = '0;
        end
        repeat (4) tick();

        // Pointer at 1, then simultaneous 1010: 3 first, then 1
        req = 4'b0010;
        tick();
        check("t4_setup_gnt", gnt, 4'b0010);
        req = '0;
        tick();
        req = 4'b1010;
        tick();
        check("t4_gnt_a", gnt, 4'b1000);
        tick();
        check("t4_gnt_b", gnt, 4'b0010);
        req = '0;
        tick();
        tick();
        check("t4_rdv_a", rd_valid, 4'b1000);
        check("t4_data_a", rd_data, rom_f(addr_of(3)));
        tick();
        check("t4_rdv_b", rd_valid, 4'b0010);
        check("t4_data_b", rd_data, rom_f(addr_of(1)));
        repeat (3) tick();

        // Reset with three reads in flight
        req = 4'b1111;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("t5_gnt", gnt, 0);
        check("t5_rom_en", rom_en, 0);
        check("t5_rom_addr", rom_addr, 0);
        check("t5_rdv", rd_valid, 0);
        check("t5_rd_data", rd_data, 0);
        req = '0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_no_rdv", rd_valid, 0);
            check("t5_no_gnt", gnt, 0);
            if (k == 4)
                req = 4'b1111;
        end
        tick();
        check("t5_first_gnt", gnt, 4'b0001);
        req = '0;
        repeat (4) tick();

`ifdef ROM_ARB_PRIO0_EN
        // Requester 0 toggling with strict priority, 1 and 2 share the rest
        do_reset();
        req = 4'b0111;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t6_gnt", gnt, 1 << p6[k-1]);
            req[0] = (k % 2 == 0);
        end
        req = '0;
        repeat (4) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
